// File: rtl/alsu_checker.sv
`default_nettype none
// ============================================================================
//  Module   : alsu_checker
//  Brief    : On-chip monitor holding a two-stage reference model of the ALSU;
//             compares it with the live ALSU outputs and keeps error statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module alsu_checker #(
    parameter int INPUT_PRIORITY = 1,
    parameter int FULL_ADDER     = 1,
    parameter int STOP_ON_ERR    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  a,
    input  logic [2:0]  b,
    input  logic [2:0]  opcode,
    input  logic        cin,
    input  logic        serial_in,
    input  logic        direction,
    input  logic        red_op_a,
    input  logic        red_op_b,
    input  logic        bypass_a,
    input  logic        bypass_b,
    input  logic [5:0]  dut_out,
    input  logic [15:0] dut_leds,
    input  logic        en,
    output logic        mismatch,
    output logic [7:0]  err_count,
    output logic [15:0] chk_count,
    output logic        first_err_valid,
    output logic [2:0]  first_err_opcode,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [7:0]  c_ERR_MAX = 8'hFF;
    localparam logic [15:0] c_CHK_MAX = 16'hFFFF;

    // Stage 1: input capture, never gated by en
    logic [2:0] r_s1_a;
    logic [2:0] r_s1_b;
    logic [2:0] r_s1_opcode;
    logic       r_s1_cin;
    logic       r_s1_serial_in;
    logic       r_s1_direction;
    logic       r_s1_red_op_a;
    logic       r_s1_red_op_b;
    logic       r_s1_bypass_a;
    logic       r_s1_bypass_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_a         <= '0;
            r_s1_b         <= '0;
            r_s1_opcode    <= '0;
            r_s1_cin       <= 1'b0;
            r_s1_serial_in <= 1'b0;
            r_s1_direction <= 1'b0;
            r_s1_red_op_a  <= 1'b0;
            r_s1_red_op_b  <= 1'b0;
            r_s1_bypass_a  <= 1'b0;
            r_s1_bypass_b  <= 1'b0;
        end else begin
            r_s1_a         <= a;
            r_s1_b         <= b;
            r_s1_opcode    <= opcode;
            r_s1_cin       <= cin;
            r_s1_serial_in <= serial_in;
            r_s1_direction <= direction;
            r_s1_red_op_a  <= red_op_a;
            r_s1_red_op_b  <= red_op_b;
            r_s1_bypass_a  <= bypass_a;
            r_s1_bypass_b  <= bypass_b;
        end
    end

    // Stage 2: expected ALSU result
    logic [5:0]  r_exp_out;
    logic [15:0] r_exp_leds;
    logic [2:0]  r_s2_opcode;

    logic        w_invalid;
    logic        w_use_red_a;
    logic        w_use_red_b;
    logic        w_cin_eff;
    logic [5:0]  w_and_res;
    logic [5:0]  w_xor_res;
    logic [5:0]  w_sum;
    logic [5:0]  w_prod;
    logic [5:0]  w_shift;
    logic [5:0]  w_rot;
    logic [5:0]  w_exp_out_nxt;
    logic [15:0] w_exp_leds_nxt;

    assign w_invalid   = (r_s1_opcode == 3'd6) || (r_s1_opcode == 3'd7) ||
                         ((r_s1_red_op_a || r_s1_red_op_b) && (r_s1_opcode >= 3'd2));
    // When both reductions are requested the priority operand wins
    assign w_use_red_a = r_s1_red_op_a && (!r_s1_red_op_b || (INPUT_PRIORITY != 0));
    assign w_use_red_b = r_s1_red_op_b && !w_use_red_a;
    assign w_cin_eff   = (FULL_ADDER != 0) && r_s1_cin;

    always_comb begin
        w_and_res = {3'b000, r_s1_a & r_s1_b};
        w_xor_res = {3'b000, r_s1_a ^ r_s1_b};
        if (w_use_red_a) begin
            w_and_res = {5'b00000, &r_s1_a};
            w_xor_res = {5'b00000, ^r_s1_a};
        end else if (w_use_red_b) begin
            w_and_res = {5'b00000, &r_s1_b};
            w_xor_res = {5'b00000, ^r_s1_b};
        end
    end

    assign w_sum   = {3'b000, r_s1_a} + {3'b000, r_s1_b} + {5'b00000, w_cin_eff};
    assign w_prod  = {3'b000, r_s1_a} * {3'b000, r_s1_b};
    assign w_shift = r_s1_direction ? {r_exp_out[4:0], r_s1_serial_in}
                                    : {r_s1_serial_in, r_exp_out[5:1]};
    assign w_rot   = r_s1_direction ? {r_exp_out[4:0], r_exp_out[5]}
                                    : {r_exp_out[0], r_exp_out[5:1]};

    always_comb begin
        w_exp_out_nxt  = '0;
        w_exp_leds_nxt = '0;
        if (r_s1_bypass_a && r_s1_bypass_b) begin
            w_exp_out_nxt = {3'b000, (INPUT_PRIORITY != 0) ? r_s1_a : r_s1_b};
        end else if (r_s1_bypass_a) begin
            w_exp_out_nxt = {3'b000, r_s1_a};
        end else if (r_s1_bypass_b) begin
            w_exp_out_nxt = {3'b000, r_s1_b};
        end else if (w_invalid) begin
            w_exp_leds_nxt = ~r_exp_leds;
        end else begin
            unique case (r_s1_opcode)
                3'd0:    w_exp_out_nxt = w_and_res;
                3'd1:    w_exp_out_nxt = w_xor_res;
                3'd2:    w_exp_out_nxt = w_sum;
                3'd3:    w_exp_out_nxt = w_prod;
                3'd4:    w_exp_out_nxt = w_shift;
                3'd5:    w_exp_out_nxt = w_rot;
                default: w_exp_out_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_out   <= '0;
            r_exp_leds  <= '0;
            r_s2_opcode <= '0;
        end else begin
            r_exp_out   <= w_exp_out_nxt;
            r_exp_leds  <= w_exp_leds_nxt;
            r_s2_opcode <= r_s1_opcode;
        end
    end

    // Control: the IDLE cycle that first sees en already loads stage 1,
    // so one WARMUP cycle completes the two-cycle pipe fill.
    state_t r_state;
    state_t w_state_nxt;
    logic   w_diff;
    logic   w_do_cmp;

    assign w_diff = (dut_out != r_exp_out) || (dut_leds != r_exp_leds);

    always_comb begin
        w_state_nxt = r_state;
        w_do_cmp    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (en) w_state_nxt = ST_WARMUP;
            end
            ST_WARMUP: begin
                w_state_nxt = en ? ST_CHECK : ST_IDLE;
            end
            ST_CHECK: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_do_cmp = 1'b1;
                    if (w_diff && (STOP_ON_ERR != 0)) w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    logic        r_mismatch;
    logic [7:0]  r_err_count;
    logic [15:0] r_chk_count;
    logic        r_first_err_valid;
    logic [2:0]  r_first_err_opcode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch         <= 1'b0;
            r_err_count        <= '0;
            r_chk_count        <= '0;
            r_first_err_valid  <= 1'b0;
            r_first_err_opcode <= '0;
        end else begin
            r_mismatch <= w_do_cmp && w_diff;
            if (w_do_cmp) begin
                if (r_chk_count != c_CHK_MAX) r_chk_count <= r_chk_count + 16'd1;
                if (w_diff) begin
                    if (r_err_count != c_ERR_MAX) r_err_count <= r_err_count + 8'd1;
                    if (!r_first_err_valid) begin
                        r_first_err_valid  <= 1'b1;
                        r_first_err_opcode <= r_s2_opcode;
                    end
                end
            end
        end
    end

    assign mismatch         = r_mismatch;
    assign err_count        = r_err_count;
    assign chk_count        = r_chk_count;
    assign first_err_valid  = r_first_err_valid;
    assign first_err_opcode = r_first_err_opcode;
    assign halted           = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_alsu_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alsu_checker
//  Brief    : Self-checking bench; two checker instances watch a behavioural
//             ALSU with optional fault injection and forced outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alsu_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] a = '0, b = '0, opcode = '0;
    logic       cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
    logic       red_op_a = 1'b0, red_op_b = 1'b0, bypass_a = 1'b0, bypass_b = 1'b0;

    logic [5:0]  inj0_out = '0, inj1_out = '0;
    logic [15:0] inj0_leds = '0, inj1_leds = '0;
    logic        f0_en = 1'b0;
    logic [5:0]  f0_out = '0;
    logic [15:0] f0_leds = '0;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] op;
        logic cin, ser, dir, ra, rb, ba, bb;
    } in_t;

    in_t         cur, h;
    logic [5:0]  r0o = '0, r1o = '0;
    logic [15:0] r0l = '0, r1l = '0;
    assign cur = {a, b, opcode, cin, serial_in, direction, red_op_a, red_op_b, bypass_a, bypass_b};

    // Behavioural ALSU: next {leds, out} from the registered inputs and previous output
    function automatic logic [21:0] alsu_next(input int pri, input int fa, input in_t x,
                                              input logic [5:0] po, input logic [15:0] pl);
        int  r;
        int  p;
        logic ua, ub;
        r = 0;
        p = int'(po);
        ua = x.ra && (!x.rb || pri != 0);
        ub = x.rb && !ua;
        if (x.ba && x.bb) r = (pri != 0) ? int'(x.a) : int'(x.b);
        else if (x.ba) r = int'(x.a);
        else if (x.bb) r = int'(x.b);
        else if (x.op >= 3'd6 || ((x.ra || x.rb) && x.op >= 3'd2)) return {~pl, 6'd0};
        else if (x.op == 3'd0) begin
            if (ua)      r = (x.a == 3'd7) ? 1 : 0;
            else if (ub) r = (x.b == 3'd7) ? 1 : 0;
            else         r = int'(x.a & x.b);
        end else if (x.op == 3'd1) begin
            if (ua)      r = $countones(x.a) % 2;
            else if (ub) r = $countones(x.b) % 2;
            else         r = int'(x.a ^ x.b);
        end else if (x.op == 3'd2) r = int'(x.a) + int'(x.b) + ((fa != 0) ? int'(x.cin) : 0);
        else if (x.op == 3'd3) r = int'(x.a) * int'(x.b);
        else if (x.op == 3'd4) r = x.dir ? ((p * 2) % 64 + int'(x.ser)) : (int'(x.ser) * 32 + p / 2);
        else                   r = x.dir ? ((p * 2) % 64 + p / 32) : ((p % 2) * 32 + p / 2);
        return {16'd0, r[5:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            h <= '0; r0o <= '0; r0l <= '0; r1o <= '0; r1l <= '0;
        end else begin
            {r0l, r0o} <= alsu_next(1, 1, h, r0o, r0l);
            {r1l, r1o} <= alsu_next(0, 0, h, r1o, r1l);
            h <= cur;
        end
    end

    logic [5:0]  dut_out0, dut_out1;
    logic [15:0] dut_leds0, dut_leds1;
    assign dut_out0  = f0_en ? f0_out  : (r0o ^ inj0_out);
    assign dut_leds0 = f0_en ? f0_leds : (r0l ^ inj0_leds);
    assign dut_out1  = r1o ^ inj1_out;
    assign dut_leds1 = r1l ^ inj1_leds;

    logic        mis0, mis1, fev0, fev1, halt0, halt1;
    logic [7:0]  err0, err1;
    logic [15:0] chk0, chk1;
    logic [2:0]  feo0, feo1;

    alsu_checker #(.INPUT_PRIORITY(1), .FULL_ADDER(1), .STOP_ON_ERR(0)) u_dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .opcode(opcode), .cin(cin),
        .serial_in(serial_in), .direction(direction), .red_op_a(red_op_a),
        .red_op_b(red_op_b), .bypass_a(bypass_a), .bypass_b(bypass_b),
        .dut_out(dut_out0), .dut_leds(dut_leds0), .en(en),
        .mismatch(mis0), .err_count(err0), .chk_count(chk0),
        .first_err_valid(fev0), .first_err_opcode(feo0), .halted(halt0));

    alsu_checker #(.INPUT_PRIORITY(0), .FULL_ADDER(0), .STOP_ON_ERR(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .opcode(opcode), .cin(cin),
        .serial_in(serial_in), .direction(direction), .red_op_a(red_op_a),
        .red_op_b(red_op_b), .bypass_a(bypass_a), .bypass_b(bypass_b),
        .dut_out(dut_out1), .dut_leds(dut_leds1), .en(en),
        .mismatch(mis1), .err_count(err1), .chk_count(chk1),
        .first_err_valid(fev1), .first_err_opcode(feo1), .halted(halt1));

    // Checker expectation: a compare happens once en has been sampled high on
    // the two preceding edges since reset, and the instance is not halted.
    int   m_run = 0;
    int   m_err [2] = '{0, 0};
    int   m_chk [2] = '{0, 0};
    int   m_feo [2] = '{0, 0};
    bit   m_mis [2] = '{0, 0};
    bit   m_fev [2] = '{0, 0};
    bit   m_halt[2] = '{0, 0};
    logic [2:0] op_d1 = '0, op_d2 = '0;

    always @(posedge clk) begin : p_model
        bit d;
        bit c;
        if (rst) begin
            m_run <= 0; op_d1 <= '0; op_d2 <= '0;
            for (int k = 0; k < 2; k++) begin
                m_err[k] <= 0; m_chk[k] <= 0; m_feo[k] <= 0;
                m_mis[k] <= 0; m_fev[k] <= 0; m_halt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                d = (k == 0) ? ((dut_out0 != r0o) || (dut_leds0 != r0l))
                             : ((dut_out1 != r1o) || (dut_leds1 != r1l));
                c = en && (m_run >= 2) && !m_halt[k];
                m_mis[k] <= c && d;
                if (c) begin
                    if (m_chk[k] < 65535) m_chk[k] <= m_chk[k] + 1;
                    if (d) begin
                        if (m_err[k] < 255) m_err[k] <= m_err[k] + 1;
                        if (!m_fev[k]) begin
                            m_fev[k] <= 1;
                            m_feo[k] <= int'(op_d2);
                        end
                        if (k == 1) m_halt[k] <= 1;
                    end
                end
            end
            m_run <= en ? ((m_run < 3) ? m_run + 1 : 3) : 0;
            op_d1 <= opcode;
            op_d2 <= op_d1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("mis0", int'(mis0), int'(m_mis[0]));
        cmp("err0", int'(err0), m_err[0]);
        cmp("chk0", int'(chk0), m_chk[0]);
        cmp("fev0", int'(fev0), int'(m_fev[0]));
        cmp("feo0", int'(feo0), m_feo[0]);
        cmp("halt0", int'(halt0), int'(m_halt[0]));
        cmp("mis1", int'(mis1), int'(m_mis[1]));
        cmp("err1", int'(err1), m_err[1]);
        cmp("chk1", int'(chk1), m_chk[1]);
        cmp("fev1", int'(fev1), int'(m_fev[1]));
        cmp("feo1", int'(feo1), m_feo[1]);
        cmp("halt1", int'(halt1), int'(m_halt[1]));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    typedef struct packed {
        logic [2:0] op, a, b;
        logic       cin, ra, rb, ba, bb;
        logic [5:0] eo;
        logic       bad;
    } vec_t;

    vec_t vt [13];
    logic [5:0] rot_exp [3];
    logic [5:0] shift_bits;

    initial begin
        // Expected results for INPUT_PRIORITY=1, FULL_ADDER=1
        vt[0]  = '{3'd2, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15, 1'b1};
        vt[1]  = '{3'd2, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15, 1'b0};
        vt[2]  = '{3'd0, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2,  1'b0};
        vt[3]  = '{3'd0, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1,  1'b0};
        vt[4]  = '{3'd0, 3'd3, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        vt[5]  = '{3'd1, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6,  1'b0};
        vt[6]  = '{3'd1, 3'd0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1,  1'b0};
        vt[7]  = '{3'd1, 3'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        vt[8]  = '{3'd3, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd49, 1'b0};
        vt[9]  = '{3'd3, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd30, 1'b1};
        vt[10] = '{3'd0, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5,  1'b0};
        vt[11] = '{3'd0, 3'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd6,  1'b0};
        vt[12] = '{3'd2, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd7,  1'b0};
        rot_exp[0] = 6'b100001;
        rot_exp[1] = 6'b000011;
        rot_exp[2] = 6'b000110;
        shift_bits = 6'b100001;

        // Reset with en high, then a clean warmup run
        rst = 1'b1; en = 1'b1;
        step(); step();
        cmp("rst_mis0", int'(mis0), 0);
        cmp("rst_err0", int'(err0), 0);
        cmp("rst_chk0", int'(chk0), 0);
        cmp("rst_fev0", int'(fev0), 0);
        cmp("rst_feo0", int'(feo0), 0);
        cmp("rst_halt0", int'(halt0), 0);
        rst = 1'b0;
        repeat (10) step();
        cmp("warm_chk0", int'(chk0), 8);
        cmp("warm_err0", int'(err0), 0);
        cmp("warm_chk1", int'(chk1), 8);

        // STOP_ON_ERR instance: error on opcode 3 halts and freezes statistics
        opcode = 3'd3; a = 3'd2; b = 3'd3;
        step(); step();
        inj1_out = 6'h04;
        step();
        cmp("halt_halted1", int'(halt1), 1);
        cmp("halt_mis1", int'(mis1), 1);
        cmp("halt_err1", int'(err1), 1);
        cmp("halt_chk1", int'(chk1), 11);
        cmp("halt_feo1", int'(feo1), 3);
        cmp("halt_chk0", int'(chk0), 11);
        repeat (3) begin
            step();
            cmp("frz_err1", int'(err1), 1);
            cmp("frz_chk1", int'(chk1), 11);
            cmp("frz_mis1", int'(mis1), 0);
            cmp("frz_halted1", int'(halt1), 1);
        end
        inj1_out = '0;
        rst = 1'b1;
        step();
        cmp("rst2_halt1", int'(halt1), 0);
        cmp("rst2_err1", int'(err1), 0);
        cmp("rst2_chk1", int'(chk1), 0);
        cmp("rst2_fev1", int'(fev1), 0);
        cmp("rst2_feo1", int'(feo1), 0);
        cmp("rst2_mis1", int'(mis1), 0);
        rst = 1'b0;

        // Vector table against forced ALSU outputs
        for (int i = 0; i < 13; i++) begin
            opcode = vt[i].op; a = vt[i].a; b = vt[i].b; cin = vt[i].cin;
            red_op_a = vt[i].ra; red_op_b = vt[i].rb;
            bypass_a = vt[i].ba; bypass_b = vt[i].bb;
            step(); step();
            f0_en = 1'b1; f0_out = vt[i].eo ^ (vt[i].bad ? 6'd1 : 6'd0); f0_leds = '0;
            step();
            cmp($sformatf("tbl%0d_mis", i), int'(mis0), int'(vt[i].bad));
            f0_en = 1'b0;
            if (i == 0) begin
                cmp("first_err0", int'(err0), 1);
                cmp("first_feo0", int'(feo0), 2);
                cmp("first_fev0", int'(fev0), 1);
            end
        end
        cmp("tbl_err0", int'(err0), 2);
        cmp("tbl_feo0", int'(feo0), 2);
        {red_op_a, red_op_b, bypass_a, bypass_b, cin} = '0;

        // Invalid opcode held: leds toggle every cycle
        opcode = 3'd6;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            f0_en = 1'b1; f0_out = '0; f0_leds = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            step();
            cmp($sformatf("inv%0d_mis", i), int'(mis0), 0);
        end
        f0_en = 1'b0;

        // Shift 100001 in, then rotate left twice
        opcode = 3'd4; direction = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            serial_in = shift_bits[i];
            step();
        end
        opcode = 3'd5; serial_in = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            f0_en = 1'b1; f0_out = rot_exp[i]; f0_leds = '0;
            step();
            cmp($sformatf("rot%0d_mis", i), int'(mis0), 0);
        end
        f0_en = 1'b0;
        cmp("rot_err0", int'(err0), 2);

        // Error counter saturation
        opcode = 3'd0; a = '0; b = '0; direction = 1'b0;
        inj0_out = 6'h01;
        repeat (300) step();
        cmp("sat_err0", int'(err0), 255);
        cmp("sat_mis0", int'(mis0), 1);
        cmp("sat_feo0", int'(feo0), 2);
        cmp("sat_fev0", int'(fev0), 1);
        inj0_out = '0;

        // Randomised traffic with en drops, resets and injected faults
        for (int n = 0; n < 600; n++) begin
            a = 3'($urandom); b = 3'($urandom); opcode = 3'($urandom);
            {cin, serial_in, direction} = 3'($urandom);
            red_op_a = ($urandom_range(0, 3) == 0);
            red_op_b = ($urandom_range(0, 3) == 0);
            bypass_a = ($urandom_range(0, 5) == 0);
            bypass_b = ($urandom_range(0, 5) == 0);
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 149) == 0);
            inj0_out  = ($urandom_range(0, 11) == 0) ? 6'($urandom) : 6'd0;
            inj1_out  = ($urandom_range(0, 29) == 0) ? 6'($urandom) : 6'd0;
            inj0_leds = ($urandom_range(0, 39) == 0) ? 16'($urandom) : 16'd0;
            step();
        end
        rst = 1'b0;
        inj0_out = '0; inj1_out = '0; inj0_leds = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alsu_checker.md
# alsu_checker

Synthesizable self-checking monitor for the `alsu` block. It watches the same input bus the ALSU receives and holds a cycle-accurate reference model of the ALSU's two register stages. Each cycle it compares the model against the ALSU's `out` and `leds`. It reports mismatches, counts checks and errors, and latches the first failing opcode, so on-chip or emulation runs can verify the ALSU without a testbench.

## Interface
Parameters:
- `INPUT_PRIORITY`, 1: bypass and reduction conflict resolution; 1 = `a` wins, 0 = `b` wins. Must match the ALSU instance.
- `FULL_ADDER`, 1: 1 = opcode 2 adds `cin`; 0 = `cin` is ignored. Must match the ALSU instance.
- `STOP_ON_ERR`, 0: 1 = enter HALT on the first mismatch.

Ports:
- `clk`  in  1  clock; the same clock as the ALSU.
- `rst`  in  1  reset, synchronous, active-high; the same reset as the ALSU.
- `a`, `b`  in  3 each  copies of the ALSU operand inputs.
- `opcode`  in  3  copy of the ALSU opcode.
- `cin`, `serial_in`, `direction`, `red_op_a`, `red_op_b`, `bypass_a`, `bypass_b`  in  1 each  copies of the ALSU control inputs.
- `dut_out`  in  6  ALSU `out`.
- `dut_leds`  in  16  ALSU `leds`.
- `en`  in  1  checking enable.
- `mismatch`  out  1  one-cycle pulse per failing compare.
- `err_count`  out  8  failing compares; saturates at 255.
- `chk_count`  out  16  compares performed; saturates at 65535.
- `first_err_valid`  out  1  sticky; set by the first mismatch.
- `first_err_opcode`  out  3  opcode of the first failing operation.
- `halted`  out  1  high while in HALT.

## Operation
**Model stage 1** registers all ALSU inputs every cycle. It is never gated by `en`.

**Model stage 2** computes `exp_out` (6 bits) and `exp_leds` (16 bits) from the stage-1 values, evaluated in this priority order:
1. Bypass: if `bypass_a` and `bypass_b` are both set, the operand selected by `INPUT_PRIORITY` is zero-extended. Otherwise the set bypass selects its operand. `exp_leds` = 0.
2. Invalid: opcode 6 or 7, or (`red_op_a` | `red_op_b`) with opcode ≥ 2. Then `exp_out` = 0 and `exp_leds` = ~`exp_leds`.
3. Valid operations. `exp_leds` = 0 for all of these.
   - Opcode 0: `a`&`b`. With `red_op_a` set, &`a`; with `red_op_b` set, &`b`; with both set, the reduction of the operand selected by `INPUT_PRIORITY`. Reduction results are zero-extended.
   - Opcode 1: the same selection as opcode 0, using XOR.
   - Opcode 2: `a`+`b`+(`FULL_ADDER` ? `cin` : 0), 6-bit result with no overflow possible.
   - Opcode 3: `a`*`b`, 6-bit result (max 49).
   - Opcode 4, shift: `direction`=1 gives {`exp_out`[4:0], `serial_in`}; `direction`=0 gives {`serial_in`, `exp_out`[5:1]}.
   - Opcode 5, rotate: `direction`=1 gives {`exp_out`[4:0], `exp_out`[5]}; `direction`=0 gives {`exp_out`[0], `exp_out`[5:1]}.

The model runs regardless of `en`, because the shift and rotate results depend on history.

**State machine:**
- IDLE: entered on reset or when `en`=0. Goes to WARMUP when `en`=1.
- WARMUP: 2 cycles, which fill the valid pipe. Then goes to CHECK. If `en` drops, returns to IDLE.
- CHECK: a compare happens every cycle. Goes to IDLE if `en`=0, or to HALT on a mismatch when `STOP_ON_ERR`=1.
- HALT: exited only by `rst`. Counters and the sticky flag are frozen.

**Compare, in CHECK only:**
- A mismatch is (`dut_out` != `exp_out`) or (`dut_leds` != `exp_leds`).
- Every compare increments `chk_count`. Each mismatch increments `err_count`.
- On the first mismatch, `first_err_valid` is set and `first_err_opcode` captures the stage-2 opcode.

**Counters** saturate at their maximum and never wrap.

## Timing
- The ALSU and the model both register inputs at edge N, and both produce outputs at edge N+1.
- The compare is combinational on the two registered values. `mismatch` is registered, so it is high during the cycle after edge N+2.
- Latency from input application to `mismatch` is 3 edges.
- `chk_count` and `err_count` update on the same edge as `mismatch`.
- Reset values: `mismatch`=0, `err_count`=0, `chk_count`=0, `first_err_valid`=0, `first_err_opcode`=0, `halted`=0. The model registers and `exp_leds` are 0 and the state is IDLE.
- Reset mid-check returns every output to its reset value on the next edge. The compare is suppressed until WARMUP completes again.
- If `en` rises while an error is already pending, WARMUP still delays the first compare by 2 cycles.
- If a mismatch and counter saturation occur together, the counter holds at its maximum and `mismatch` still pulses.

## Test plan
- Reset with all inputs 0 and `en`=1 for 10 cycles, ALSU correct: `chk_count`=8 and `err_count`=0 after the 2-cycle warmup.
- Opcode 2, `a`=7, `b`=7, `cin`=1, `FULL_ADDER`=1, with `dut_out` forced to 14: `mismatch` pulses 3 edges later, `err_count`=1, `first_err_opcode`=2.
- Opcode 6 held for 4 cycles with the real ALSU: `exp_leds` alternates FFFF/0000 and no mismatch occurs.
- Opcode 5, `direction`=1, starting from `out`=6'b100001: the model gives 000011 and then 000110, with no mismatch against the real ALSU.
- `STOP_ON_ERR`=1 and an injected error on opcode 3: `halted`=1 and the counters are frozen despite further errors. `rst` clears all outputs.
- Force 300 mismatches: `err_count` saturates at 255, and `first_err_opcode` keeps its first value.
